// File: rtl/pkt_dcache.sv
// pkt_dcache: packet data cache between ingress and the egress build module.
// Complete, valid packets are stored in fixed-size slots and announced as
// {len_m1, slot_id}. A returned slot ID streams the packet back out and frees
// the slot.
// Build option: define DCACHE_DROP_CNT_EN to implement the saturating
// dropped-packet counter; otherwise out_dcache_drop_cnt is tied to zero.
//
// state   | meaning
// W_IDLE  | waiting for a head beat
// W_STORE | writing beats of the current packet into wr_slot_q
// W_DROP  | discarding beats until the next tail
// R_IDLE  | waiting for a rising edge on in_dcache_ID_wr
// R_READ  | streaming beats 0..len of rd_slot_q
module pkt_dcache #(
  parameter int SLOT_NUM   = 4,
  parameter int SLOT_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [133:0] in_dcache_data,
  input  logic         in_dcache_data_wr,
  input  logic         in_dcache_valid,
  input  logic         in_dcache_valid_wr,
  output logic [11:0]  out_dcache_md,
  output logic         out_dcache_md_wr,
  input  logic [7:0]   in_dcache_ID,
  input  logic         in_dcache_ID_wr,
  output logic [133:0] out_dcache_data,
  output logic         out_dcache_data_wr,
  output logic         out_dcache_valid,
  output logic         out_dcache_valid_wr,
  output logic [15:0]  out_dcache_drop_cnt
);
  localparam int SW = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
  localparam int BW = $clog2(SLOT_DEPTH);
  localparam int AW = SW + BW;

  localparam logic [1:0] S_FREE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} w_state_t;
  typedef enum logic {R_IDLE, R_READ} r_state_t;

  w_state_t        w_state_q, w_state_d;
  r_state_t        r_state_q, r_state_d;
  logic [1:0]      slot_st_q  [SLOT_NUM];
  logic [1:0]      slot_st_d  [SLOT_NUM];
  logic [3:0]      slot_len_q [SLOT_NUM];
  logic [3:0]      slot_len_d [SLOT_NUM];
  logic [SW-1:0]   wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [BW:0]     wr_beat_q, wr_beat_d;
  logic [3:0]      rd_beat_q, rd_beat_d;
  logic            id_wr_prev_q, id_wr_prev_d;
  logic [11:0]     md_q, md_d;
  logic            md_wr_q, md_wr_d;
  logic [133:0]    rd_data_q, rd_data_d;
  logic            data_wr_q, data_wr_d;
  logic            valid_q, valid_d;

  logic [133:0]    mem [2**AW];
  logic            mem_we, rd_en, drop_evt;
  logic [AW-1:0]   mem_waddr, rd_addr;
  logic            free_found;
  logic [SW-1:0]   free_idx, req_idx;

  logic is_head, is_tail, keep, beat_ovf, id_rise, id_ok, rd_last;
  assign is_head  = in_dcache_data_wr && (in_dcache_data[133:132] == 2'b01);
  assign is_tail  = in_dcache_data_wr && (in_dcache_data[133:132] == 2'b10);
  assign keep     = in_dcache_valid_wr && in_dcache_valid;
  assign beat_ovf = (wr_beat_q == (BW+1)'(SLOT_DEPTH));
  assign id_rise  = in_dcache_ID_wr && !id_wr_prev_q;
  assign req_idx  = in_dcache_ID[SW-1:0];
  assign id_ok    = ({1'b0, in_dcache_ID} < 9'(SLOT_NUM)) && (slot_st_q[req_idx] == S_READY);
  assign rd_last  = (rd_beat_q == slot_len_q[rd_slot_q]);

  // Lowest-index FREE slot from registered slot state.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = SLOT_NUM - 1; i >= 0; i--) begin
      if (slot_st_q[i] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  // Next-state logic for the write and read FSMs.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (is_head) w_state_d = free_found ? W_STORE : W_DROP;
      W_STORE: begin
        if (is_tail) w_state_d = W_IDLE;
        else if (in_dcache_data_wr && !is_head && beat_ovf) w_state_d = W_DROP;
      end
      W_DROP:  if (is_tail) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: if (id_rise && id_ok) r_state_d = R_READ;
      R_READ: if (rd_last) r_state_d = R_IDLE;
    endcase
  end

  // Datapath and slot bookkeeping driven by the FSM states.
  always_comb begin
    slot_st_d    = slot_st_q;
    slot_len_d   = slot_len_q;
    wr_slot_d    = wr_slot_q;
    wr_beat_d    = wr_beat_q;
    rd_slot_d    = rd_slot_q;
    rd_beat_d    = rd_beat_q;
    id_wr_prev_d = in_dcache_ID_wr;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    rd_en        = 1'b0;
    rd_addr      = '0;
    drop_evt     = 1'b0;
    md_wr_d      = 1'b0;
    md_d         = '0;
    case (w_state_q)
      W_IDLE: begin
        if (is_head) begin
          if (free_found) begin
            slot_st_d[free_idx] = S_FILL;
            wr_slot_d           = free_idx;
            mem_we              = 1'b1;
            mem_waddr           = {free_idx, BW'(0)};
            wr_beat_d           = (BW+1)'(1);
          end else begin
            drop_evt = 1'b1;
          end
        end
      end
      W_STORE: begin
        if (is_head) begin
          // Missing tail: abandon the partial packet and restart in place.
          drop_evt  = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = {wr_slot_q, BW'(0)};
          wr_beat_d = (BW+1)'(1);
        end else if (in_dcache_data_wr) begin
          if (beat_ovf) begin
            slot_st_d[wr_slot_q] = S_FREE;
            drop_evt             = 1'b1;
          end else if (is_tail) begin
            if (keep) begin
              mem_we                = 1'b1;
              mem_waddr             = {wr_slot_q, wr_beat_q[BW-1:0]};
              slot_st_d[wr_slot_q]  = S_READY;
              slot_len_d[wr_slot_q] = 4'(wr_beat_q);
              md_wr_d               = 1'b1;
              md_d                  = {4'(wr_beat_q), 8'(wr_slot_q)};
            end else begin
              slot_st_d[wr_slot_q] = S_FREE;
            end
          end else begin
            mem_we    = 1'b1;
            mem_waddr = {wr_slot_q, wr_beat_q[BW-1:0]};
            wr_beat_d = wr_beat_q + (BW+1)'(1);
          end
        end
      end
      default: ;
    endcase
    case (r_state_q)
      R_IDLE: begin
        if (id_rise && id_ok) begin
          slot_st_d[req_idx] = S_READ;
          rd_slot_d          = req_idx;
          rd_beat_d          = 4'd0;
        end
      end
      R_READ: begin
        rd_en     = 1'b1;
        rd_addr   = {rd_slot_q, rd_beat_q[BW-1:0]};
        rd_beat_d = rd_beat_q + 4'd1;
        if (rd_last) slot_st_d[rd_slot_q] = S_FREE;
      end
    endcase
    rd_data_d = rd_en ? mem[rd_addr] : '0;
    data_wr_d = rd_en;
    valid_d   = rd_en && rd_last;
  end

  // Packet storage, written on accepted ingress beats.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_dcache_data;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      for (int i = 0; i < SLOT_NUM; i++) begin
        slot_st_q[i]  <= S_FREE;
        slot_len_q[i] <= '0;
      end
      wr_slot_q    <= '0;
      wr_beat_q    <= '0;
      rd_slot_q    <= '0;
      rd_beat_q    <= '0;
      id_wr_prev_q <= 1'b0;
      md_q         <= '0;
      md_wr_q      <= 1'b0;
      rd_data_q    <= '0;
      data_wr_q    <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      slot_st_q    <= slot_st_d;
      slot_len_q   <= slot_len_d;
      wr_slot_q    <= wr_slot_d;
      wr_beat_q    <= wr_beat_d;
      rd_slot_q    <= rd_slot_d;
      rd_beat_q    <= rd_beat_d;
      id_wr_prev_q <= id_wr_prev_d;
      md_q         <= md_d;
      md_wr_q      <= md_wr_d;
      rd_data_q    <= rd_data_d;
      data_wr_q    <= data_wr_d;
      valid_q      <= valid_d;
    end
  end

`ifdef DCACHE_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped packets.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_evt && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign out_dcache_drop_cnt = drop_cnt_q;
`else
  logic unused_drop_evt;
  assign unused_drop_evt     = drop_evt;
  assign out_dcache_drop_cnt = '0;
`endif

  assign out_dcache_md       = md_q;
  assign out_dcache_md_wr    = md_wr_q;
  assign out_dcache_data     = rd_data_q;
  assign out_dcache_data_wr  = data_wr_q;
  assign out_dcache_valid    = valid_q;
  assign out_dcache_valid_wr = valid_q;
endmodule

// File: tb/tb_pkt_dcache.sv
// Testbench for pkt_dcache: directed test-plan steps followed by random
// store/read traffic, checked against a slot-level behavioural model.
module tb_pkt_dcache;
  localparam int SN = 4;
  localparam int SD = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [133:0] in_data;
  logic         in_data_wr, in_valid, in_valid_wr;
  logic [11:0]  md;
  logic         md_wr;
  logic [7:0]   in_id;
  logic         in_id_wr;
  logic [133:0] out_data;
  logic         out_data_wr, out_valid, out_valid_wr;
  logic [15:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: per slot 0=free, 1=holding a stored packet; stored beats and length.
  int           mst  [SN];
  int           mlen [SN];
  logic [133:0] mdat [SN][SD];
  int           mdrop;

  pkt_dcache #(.SLOT_NUM(SN), .SLOT_DEPTH(SD)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_dcache_data      (in_data),
    .in_dcache_data_wr   (in_data_wr),
    .in_dcache_valid     (in_valid),
    .in_dcache_valid_wr  (in_valid_wr),
    .out_dcache_md       (md),
    .out_dcache_md_wr    (md_wr),
    .in_dcache_ID        (in_id),
    .in_dcache_ID_wr     (in_id_wr),
    .out_dcache_data     (out_data),
    .out_dcache_data_wr  (out_data_wr),
    .out_dcache_valid    (out_valid),
    .out_dcache_valid_wr (out_valid_wr),
    .out_dcache_drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop();
`ifdef DCACHE_DROP_CNT_EN
    return 16'(mdrop);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [133:0] rnd_beat(input logic [1:0] hdr);
    return {hdr, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom), 4'($urandom)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SN; i++) begin
      mst[i]  = 0;
      mlen[i] = 0;
    end
    mdrop = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_data_wr"}, 134'(out_data_wr), 134'(0));
    chk({tag, "_data"}, out_data, 134'(0));
    chk({tag, "_valid"}, 134'(out_valid), 134'(0));
    chk({tag, "_valid_wr"}, 134'(out_valid_wr), 134'(0));
    chk({tag, "_md_wr"}, 134'(md_wr), 134'(0));
    chk({tag, "_md"}, 134'(md), 134'(0));
    chk({tag, "_drop"}, 134'(drop_cnt), 134'(exp_drop()));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_data = '0; in_data_wr = 0; in_valid = 0; in_valid_wr = 0;
    in_id = '0; in_id_wr = 0;
    tick();
    tick();
    rst = 1'b0;
    model_clear();
    check_idle_outputs("reset");
  endtask

  // Drive one packet on consecutive cycles; expect md exactly one cycle after the tail.
  task automatic send_pkt(input int len, input bit keep);
    int id = -1;
    bit exp_md;
    logic [1:0] hdr;
    logic [133:0] beat;
    for (int i = 0; i < SN; i++) if (id < 0 && mst[i] == 0) id = i;
    if (id < 0 || len > SD) mdrop++;
    exp_md = (id >= 0) && (len <= SD) && keep;
    for (int b = 0; b < len; b++) begin
      hdr = (b == 0) ? 2'b01 : (b == len - 1) ? 2'b10 : ($urandom_range(0, 1) == 0 ? 2'b00 : 2'b11);
      beat = rnd_beat(hdr);
      in_data     = beat;
      in_data_wr  = 1'b1;
      in_valid_wr = (b == len - 1);
      in_valid    = keep && (b == len - 1);
      if (exp_md) mdat[id][b] = beat;
      tick();
      if (b == len - 1) begin
        chk("md_wr_after_tail", 134'(md_wr), 134'(exp_md));
        if (exp_md) chk("md_value", 134'(md), 134'({4'(len - 1), 8'(id)}));
      end else begin
        chk("md_wr_mid_pkt", 134'(md_wr), 134'(0));
      end
    end
    in_data = '0; in_data_wr = 0; in_valid = 0; in_valid_wr = 0;
    if (exp_md) begin
      mst[id]  = 1;
      mlen[id] = len;
    end
    tick();
    chk("md_wr_one_cycle", 134'(md_wr), 134'(0));
    chk("drop_cnt", 134'(drop_cnt), 134'(exp_drop()));
  endtask

  // Request a slot, hold ID_wr for the transfer plus 'hold' extra cycles.
  task automatic read_req(input int id, input int hold);
    bit ok = (id < SN) && (mst[id] == 1);
    int n = ok ? mlen[id] : 0;
    bit ew;
    in_id    = 8'(id);
    in_id_wr = 1'b1;
    for (int k = 1; k <= n + 1 + hold; k++) begin
      tick();
      ew = ok && (k >= 2) && (k < 2 + n);
      chk("rd_data_wr", 134'(out_data_wr), 134'(ew));
      chk("rd_data", out_data, ew ? mdat[id][k-2] : 134'(0));
      chk("rd_valid", 134'(out_valid), 134'(ew && (k - 2 == n - 1)));
      chk("rd_valid_wr", 134'(out_valid_wr), 134'(ew && (k - 2 == n - 1)));
    end
    in_id_wr = 1'b0;
    tick();
    if (ok) mst[id] = 0;
  endtask

  initial begin
    int len;
    do_reset();

    // Store and read: 4-beat packet -> md 0x300, then stream it back.
    send_pkt(4, 1);
    read_req(0, 2);
    send_pkt(2, 1);
    read_req(0, 1);

    // Discard: invalid packet gives no md, next packet reuses slot 0.
    send_pkt(3, 0);
    send_pkt(2, 1);
    read_req(0, 1);

    // Full: four stored packets, fifth is dropped; freed slot 2 is reused.
    for (int i = 0; i < SN; i++) send_pkt(i + 2, 1);
    send_pkt(3, 1);
    read_req(2, 1);
    send_pkt(5, 1);
    for (int i = 0; i < SN; i++) read_req(i, 1);

    // Overflow: 17 beats dropped, slot freed, next 2-beat packet is md 0x100.
    send_pkt(17, 1);
    send_pkt(2, 1);
    read_req(0, 1);

    // Bad requests and a long-held ID_wr.
    read_req(3, 4);
    read_req(9, 3);
    send_pkt(6, 1);
    read_req(0, 10);

    // Random traffic.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 2) begin
        len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 18)) : int'($urandom_range(2, 16));
        send_pkt(len, $urandom_range(0, 3) != 0);
      end else begin
        read_req(int'($urandom_range(0, 5)), int'($urandom_range(1, 3)));
      end
    end

    // Reset in the middle of a read.
    do_reset();
    send_pkt(6, 1);
    in_id    = 8'd0;
    in_id_wr = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("mid_rd_data_wr", 134'(out_data_wr), 134'(k >= 2));
      chk("mid_rd_data", out_data, (k >= 2) ? mdat[0][k-2] : 134'(0));
    end
    rst = 1'b1;
    tick();
    model_clear();
    check_idle_outputs("rst_mid_read");
    rst      = 1'b0;
    in_id_wr = 1'b0;
    tick();
    send_pkt(2, 1);
    send_pkt(3, 1);
    read_req(0, 1);
    read_req(1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
